// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache main-memory arbiter: state encodings,
// block alignment mask and the fill address helper.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_D_FILL  = 2'd1,
        ST_I_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } arb_state_t;

    localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;
    localparam int          DEF_MEM_LATENCY = 4;

    // Word k of the 16-byte block containing addr; never leaves the block.
    function automatic logic [15:0] fill_addr(input logic [15:0] addr, input logic [2:0] k);
        return (addr & BLOCK_MASK) + {12'd0, k, 1'b0};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_fill_counter.sv
// Issue and return word counters for one block fill; cleared whenever the
// arbiter is not filling so every fill starts from word 0.
module cache_fill_counter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       issue_en,
    input  logic       ret_en,
    output logic [2:0] issue_cnt,
    output logic [2:0] ret_cnt,
    output logic       issue_active,
    output logic       last_return
);

    localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

    logic issue_done;

    assign issue_active = issue_en && !issue_done;
    assign last_return  = ret_en && (ret_cnt == LAST_WORD);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            issue_cnt  <= 3'd0;
            ret_cnt    <= 3'd0;
            issue_done <= 1'b0;
        end else begin
            if (issue_active) begin
                if (issue_cnt == LAST_WORD) begin
                    issue_done <= 1'b1;
                end else begin
                    issue_cnt <= issue_cnt + 3'd1;
                end
            end
            if (ret_en) begin
                ret_cnt <= ret_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single pipelined memory port between I-cache and D-cache:
// 8-word block fills for either cache and single-word D-cache write-through stores.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int BLOCK_WORDS = 8,
    parameter int PRIORITY_RR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_data_valid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_data_valid,
    output logic        d_done,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic        busy
);

    arb_state_t  state, next_state;
    logic        pick_d;
    logic        served_d;
    logic [7:0]  drain;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

    logic        in_fill, in_write, ret_en;
    logic [2:0]  issue_cnt, ret_cnt;
    logic        issue_active, last_return;

    assign in_fill  = (state == ST_D_FILL) || (state == ST_I_FILL);
    assign in_write = (state == ST_D_WRITE);
    // Returns still in flight from before a reset are swallowed for MEM_LATENCY cycles.
    assign ret_en   = in_fill && mem_data_valid && (drain == 8'd0);

    cache_fill_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_fill_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!in_fill),
        .issue_en     (in_fill),
        .ret_en       (ret_en),
        .issue_cnt    (issue_cnt),
        .ret_cnt      (ret_cnt),
        .issue_active (issue_active),
        .last_return  (last_return)
    );

    always_comb begin
        next_state = state;
        pick_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                pick_d = d_req && (!i_req || (PRIORITY_RR == 0) || !served_d);
                if (pick_d) begin
                    next_state = d_wr ? ST_D_WRITE : ST_D_FILL;
                end else if (i_req) begin
                    next_state = ST_I_FILL;
                end
            end
            ST_D_FILL, ST_I_FILL: begin
                if (last_return) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            served_d <= 1'b0;
            drain    <= 8'(MEM_LATENCY);
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state != ST_IDLE) begin
                served_d <= (next_state != ST_I_FILL);
            end
            if (drain != 8'd0) begin
                drain <= drain - 8'd1;
            end
        end
    end

    // Address and store data are captured on grant; later request changes are ignored.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            addr_q  <= pick_d ? d_addr : i_addr;
            wdata_q <= d_wdata;
        end
    end

    assign busy         = (state != ST_IDLE);
    assign i_grant      = (state == ST_I_FILL);
    assign d_grant      = (state == ST_D_FILL) || in_write;
    assign i_data_valid = ret_en && (state == ST_I_FILL);
    assign d_data_valid = ret_en && (state == ST_D_FILL);
    assign i_done       = last_return && (state == ST_I_FILL);
    assign d_done       = (last_return && (state == ST_D_FILL)) || in_write;
    assign fill_word    = ret_en ? ret_cnt : 3'd0;
    assign fill_data    = ret_en ? mem_rdata : 16'd0;

    assign mem_en    = issue_active || in_write;
    assign mem_wr    = in_write;
    assign mem_addr  = in_write     ? addr_q :
                       issue_active ? fill_addr(addr_q, issue_cnt) : 16'd0;
    assign mem_wdata = in_write ? wdata_q : 16'd0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: fixed-priority (instance 0) and round-robin
// (instance 1) arbiters, each on a latency-4 pipelined memory model.
module tb_cache_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_clr;

    logic        i_req          [2];
    logic [15:0] i_addr         [2];
    logic        i_grant        [2];
    logic        i_data_valid   [2];
    logic        i_done         [2];
    logic        d_req          [2];
    logic        d_wr           [2];
    logic [15:0] d_addr         [2];
    logic [15:0] d_wdata        [2];
    logic        d_grant        [2];
    logic        d_data_valid   [2];
    logic        d_done         [2];
    logic [2:0]  fill_word      [2];
    logic [15:0] fill_data      [2];
    logic        mem_en         [2];
    logic        mem_wr         [2];
    logic [15:0] mem_addr       [2];
    logic [15:0] mem_wdata      [2];
    logic [15:0] mem_rdata      [2];
    logic        mem_data_valid [2];
    logic        busy           [2];
    logic        inj            [2];

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard entries: {is_d, word index, data}
    logic [19:0] sbq0[$];
    logic [19:0] sbq1[$];
    logic [19:0] mon_got, mon_exp;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_mem_arbiter #(
            .MEM_LATENCY (LAT),
            .BLOCK_WORDS (8),
            .PRIORITY_RR (g)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_req          (i_req[g]),
            .i_addr         (i_addr[g]),
            .i_grant        (i_grant[g]),
            .i_data_valid   (i_data_valid[g]),
            .i_done         (i_done[g]),
            .d_req          (d_req[g]),
            .d_wr           (d_wr[g]),
            .d_addr         (d_addr[g]),
            .d_wdata        (d_wdata[g]),
            .d_grant        (d_grant[g]),
            .d_data_valid   (d_data_valid[g]),
            .d_done         (d_done[g]),
            .fill_word      (fill_word[g]),
            .fill_data      (fill_data[g]),
            .mem_en         (mem_en[g]),
            .mem_wr         (mem_wr[g]),
            .mem_addr       (mem_addr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_rdata      (mem_rdata[g]),
            .mem_data_valid (mem_data_valid[g]),
            .busy           (busy[g])
        );

        // Memory model: read data = address ^ A5A5, returned LAT cycles after mem_en.
        // Not reset by rst_n, so reads issued before a DUT reset still come back.
        logic [LAT-1:0] pv;
        logic [15:0]    pd [LAT];
        always @(posedge clk) begin
            if (mem_clr) pv <= '0;
            else         pv <= {pv[LAT-2:0], mem_en[g] & ~mem_wr[g]};
            pd[0] <= mem_addr[g] ^ 16'hA5A5;
            for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
        end
        assign mem_data_valid[g] = pv[LAT-1] | inj[g];
        assign mem_rdata[g]      = pv[LAT-1] ? pd[LAT-1] : 16'h0000;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_out(input int g);
        return {5'd0, i_grant[g], i_data_valid[g], i_done[g], d_grant[g], d_data_valid[g],
                d_done[g], fill_word[g], fill_data[g], mem_en[g], mem_wr[g], mem_addr[g],
                mem_wdata[g], busy[g]};
    endfunction

    task automatic push_fill(input int inst, input logic is_d, input logic [15:0] addr, input int n);
        logic [19:0] e;
        for (int k = 0; k < n; k++) begin
            e = {is_d, 3'(k), ((addr & 16'hFFF0) + 16'(2 * k)) ^ 16'hA5A5};
            if (inst == 0) sbq0.push_back(e);
            else           sbq1.push_back(e);
        end
    endtask

    function automatic int sb_size(input int inst);
        return (inst == 0) ? sbq0.size() : sbq1.size();
    endfunction

    task automatic run_fill(input int inst, input logic is_d, input logic [15:0] addr);
        int dc;
        dc = -1;
        @(negedge clk);
        push_fill(inst, is_d, addr, 8);
        if (is_d) begin
            d_wr[inst] = 1'b0; d_addr[inst] = addr; d_req[inst] = 1'b1;
        end else begin
            i_addr[inst] = addr; i_req[inst] = 1'b1;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((is_d ? d_done[inst] : i_done[inst]) === 1'b1) begin
                dc = c;
                break;
            end
        end
        d_req[inst] = 1'b0;
        i_req[inst] = 1'b0;
        check("fill_done_cycle", 64'(dc), 64'(11));
        @(negedge clk);
        check("fill_busy_after", busy[inst], 0);
        check("fill_sb_empty", 64'(sb_size(inst)), 0);
    endtask

    // Every forwarded word is checked against the scoreboard, in order.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (i_data_valid[g] === 1'b1 || d_data_valid[g] === 1'b1) begin
                mon_got = {d_data_valid[g], fill_word[g], fill_data[g]};
                if (i_data_valid[g] === 1'b1 && d_data_valid[g] === 1'b1) begin
                    check("both_valid", 1, 0);
                end else if (sb_size(g) == 0) begin
                    check("unexpected_word", 64'(mon_got), 0);
                end else begin
                    mon_exp = (g == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    check("sb_word", 64'(mon_got), 64'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ig_first, dd, idn, viol, seen, fwd, n, dn;
        logic ord [4];
        logic wb;

        for (int g = 0; g < 2; g++) begin
            i_req[g] = 0; i_addr[g] = 0; d_req[g] = 0; d_wr[g] = 0;
            d_addr[g] = 0; d_wdata[g] = 0; inj[g] = 0;
        end
        rst_n = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs0", all_out(0), 0);
        check("reset_outs1", all_out(1), 0);
        rst_n = 1'b1;
        mem_clr = 1'b0;

        // I fill from 0x1234
        @(negedge clk);
        i_addr[0] = 16'h1234; i_req[0] = 1'b1;
        push_fill(0, 1'b0, 16'h1234, 8);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 8) check("t1_issue", {mem_en[0], mem_wr[0], mem_addr[0]},
                             {1'b1, 1'b0, 16'h1230 + 16'(2 * c)});
            else       check("t1_no_issue", mem_en[0], 0);
            check("t1_valid", {i_data_valid[0], d_data_valid[0]}, {(c >= 4 && c <= 11), 1'b0});
            check("t1_done", i_done[0], (c == 11));
            check("t1_busy", busy[0], (c <= 11));
            if (i_done[0] === 1'b1) i_req[0] = 1'b0;
        end
        i_req[0] = 1'b0;
        check("t1_sb_empty", 64'(sbq0.size()), 0);

        // Simultaneous I and D fill requests, fixed priority
        @(negedge clk);
        d_wr[0] = 1'b0; d_addr[0] = 16'h0040; d_req[0] = 1'b1;
        i_addr[0] = 16'h0100; i_req[0] = 1'b1;
        push_fill(0, 1'b1, 16'h0040, 8);
        push_fill(0, 1'b0, 16'h0100, 8);
        ig_first = -1; dd = -1; idn = -1; viol = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) check("t2_d_first", {d_grant[0], i_grant[0]}, 2'b10);
            if (d_grant[0] === 1'b1 && i_data_valid[0] === 1'b1) viol++;
            if (i_grant[0] === 1'b1 && ig_first < 0) ig_first = c;
            if (d_done[0] === 1'b1 && dd < 0) begin dd = c; d_req[0] = 1'b0; end
            if (i_done[0] === 1'b1) begin idn = c; i_req[0] = 1'b0; break; end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        check("t2_d_done", 64'(dd), 64'(11));
        check("t2_gap", 64'(ig_first), 64'(dd + 2));
        check("t2_no_ivld", 64'(viol), 0);
        check("t2_i_done", 64'(idn), 64'(dd + 2 + 11));
        @(negedge clk);
        check("t2_sb_empty", 64'(sbq0.size()), 0);

        // Single-word store
        @(negedge clk);
        d_wr[0] = 1'b1; d_addr[0] = 16'h00A2; d_wdata[0] = 16'hBEEF; d_req[0] = 1'b1;
        @(negedge clk);
        check("t3_write", {mem_en[0], mem_wr[0], mem_addr[0], mem_wdata[0], d_done[0], d_grant[0]},
              {1'b1, 1'b1, 16'h00A2, 16'hBEEF, 1'b1, 1'b1});
        d_req[0] = 1'b0; d_wr[0] = 1'b0; d_wdata[0] = 16'h0000;
        @(negedge clk);
        check("t3_after", {busy[0], mem_en[0], d_done[0]}, 0);

        // Reset after 3 words of an I fill
        @(negedge clk);
        i_addr[0] = 16'h2000; i_req[0] = 1'b1;
        push_fill(0, 1'b0, 16'h2000, 3);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i_data_valid[0] === 1'b1) seen++;
            if (seen == 3) break;
        end
        check("t4_three_words", 64'(seen), 3);
        rst_n = 1'b0; i_req[0] = 1'b0;
        @(negedge clk);
        check("t4_outs_zero", all_out(0), 0);
        rst_n = 1'b1;
        fwd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (i_data_valid[0] === 1'b1 || d_data_valid[0] === 1'b1) fwd++;
        end
        check("t4_no_forward", 64'(fwd), 0);
        check("t4_sb_empty", 64'(sbq0.size()), 0);

        // Stray mem_data_valid while idle, then a D fill must start at word 0
        @(negedge clk);
        inj[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_idle_valid", {i_data_valid[0], d_data_valid[0]}, 0);
        end
        inj[0] = 1'b0;
        run_fill(0, 1'b1, 16'h0306);
        run_fill(0, 1'b0, 16'hFFF8);

        // Round-robin instance, both requesting continuously
        @(negedge clk);
        d_wr[1] = 1'b0; d_addr[1] = 16'h0400; i_addr[1] = 16'h0500;
        d_req[1] = 1'b1; i_req[1] = 1'b1;
        push_fill(1, 1'b1, 16'h0400, 8);
        push_fill(1, 1'b0, 16'h0500, 8);
        push_fill(1, 1'b1, 16'h0400, 8);
        push_fill(1, 1'b0, 16'h0500, 8);
        n = 0; dn = 0; wb = 1'b0;
        for (int k = 0; k < 4; k++) ord[k] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy[1] === 1'b1 && !wb) begin
                if (n < 4) ord[n] = d_grant[1];
                n++;
            end
            wb = busy[1];
            if (d_done[1] === 1'b1 || i_done[1] === 1'b1) begin
                dn++;
                if (dn == 4) begin d_req[1] = 1'b0; i_req[1] = 1'b0; break; end
            end
        end
        d_req[1] = 1'b0; i_req[1] = 1'b0;
        @(negedge clk);
        check("t5_grants", 64'(n), 4);
        check("t5_order", {ord[0], ord[1], ord[2], ord[3]}, 4'b1010);
        check("t5_sb_empty", 64'(sbq1.size()), 0);
        check("t5_idle", busy[1], 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
